// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO with sticky overrun/framing error flags
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rd_en,
  input  logic               clear_err,
  output logic [7:0]         rx_byte,
  output logic               rx_ready,
  output logic [FIFO_AW:0]   rx_count,
  output logic               overrun,
  output logic               frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state;
  logic s1, rxs;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic stop_hit, push, ferr_ev, empty, full, do_pop, do_push, ovr_ev;
  always_comb begin
    stop_hit = state == STOP && cnt == FULL_BIT;
    push = stop_hit && rxs;
    ferr_ev = stop_hit && !rxs;
    empty = rx_count == '0;
    full = rx_count == FULL_CNT;
    do_pop = rd_en && !empty;
    do_push = push && (!full || do_pop);
    ovr_ev = push && full && !rd_en;
    rx_ready = !empty;
    rx_byte = empty ? 8'h00 : mem[rp];
  end
  always_ff @(posedge clk)
    if (!rst) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {rx, s1};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START:
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? IDLE : DATA;
          end else cnt <= cnt + CW'(1);
        DATA:
          if (cnt == FULL_BIT) begin
            cnt <= '0;
            shift[idx] <= rxs;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + CW'(1);
        STOP:
          if (cnt == FULL_BIT) begin
            cnt <= '0;
            state <= rxs ? IDLE : BRK;
          end else cnt <= cnt + CW'(1);
        BRK: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= shift;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      rx_count <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wp <= wp + FIFO_AW'(1);
      if (do_pop) rp <= rp + FIFO_AW'(1);
      rx_count <= rx_count + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};
      overrun <= ovr_ev || (overrun && !clear_err);
      frame_err <= ferr_ev || (frame_err && !clear_err);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, rd_en = 1'b0, clear_err = 1'b0;
  logic [7:0] rx_byte;
  logic rx_ready, overrun, frame_err;
  logic [2:0] rx_count;
  logic [13:0] st;
  int checks = 0, errors = 0;
  assign st = {rx_ready, rx_count, rx_byte, overrun, frame_err};
  uart_rx_fifo #(.CLKS_PER_BIT(8), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .clear_err(clear_err),
    .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic send_bits(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bits(b);
    rx = stop;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (st !== 14'h0) begin errors++; $display("FAIL reset_state got %h exp %h", st, 14'h0); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_basic();
    send_bits(8'hA5);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL latency_early rx_ready got %b exp 0", rx_ready); end
    @(negedge clk);
    checks++;
    if (st !== {1'b1, 3'd1, 8'hA5, 2'b00}) begin errors++; $display("FAIL basic_rx got %h exp %h", st, {1'b1, 3'd1, 8'hA5, 2'b00}); end
    repeat (4) @(negedge clk);
    pop();
    checks++;
    if (st !== 14'h0) begin errors++; $display("FAIL basic_pop got %h exp %h", st, 14'h0); end
  endtask
  task automatic test_glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (st !== 14'h0) begin errors++; $display("FAIL glitch_reject got %h exp %h", st, 14'h0); end
    send_byte(8'h5A, 1'b1);
    checks++;
    if (st !== {1'b1, 3'd1, 8'h5A, 2'b00}) begin errors++; $display("FAIL after_glitch got %h exp %h", st, {1'b1, 3'd1, 8'h5A, 2'b00}); end
    pop();
  endtask
  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    checks++;
    if (st !== {1'b1, 3'd4, 8'h01, 2'b10}) begin errors++; $display("FAIL overrun_fill got %h exp %h", st, {1'b1, 3'd4, 8'h01, 2'b10}); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rx_byte !== 8'(i)) begin errors++; $display("FAIL overrun_order got %h exp %h", rx_byte, 8'(i)); end
      pop();
    end
    checks++;
    if (st !== {1'b0, 3'd0, 8'h00, 2'b10}) begin errors++; $display("FAIL drained got %h exp %h", st, {1'b0, 3'd0, 8'h00, 2'b10}); end
    pop();
    checks++;
    if (st !== {1'b0, 3'd0, 8'h00, 2'b10}) begin errors++; $display("FAIL empty_pop got %h exp %h", st, {1'b0, 3'd0, 8'h00, 2'b10}); end
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checks++;
    if (st !== 14'h0) begin errors++; $display("FAIL clear_err got %h exp %h", st, 14'h0); end
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h23, 1'b1);
    checks++;
    if (st !== {1'b1, 3'd3, 8'h21, 2'b00}) begin errors++; $display("FAIL wrap_fill got %h exp %h", st, {1'b1, 3'd3, 8'h21, 2'b00}); end
    pop();
    checks++;
    if (rx_byte !== 8'h22) begin errors++; $display("FAIL wrap_second got %h exp 22", rx_byte); end
    pop();
    checks++;
    if (rx_byte !== 8'h23) begin errors++; $display("FAIL wrap_third got %h exp 23", rx_byte); end
    pop();
    checks++;
    if (st !== 14'h0) begin errors++; $display("FAIL wrap_drain got %h exp %h", st, 14'h0); end
  endtask
  task automatic test_frame_err();
    send_bits(8'h3C);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (st !== {1'b0, 3'd0, 8'h00, 2'b01}) begin errors++; $display("FAIL frame_err_set got %h exp %h", st, {1'b0, 3'd0, 8'h00, 2'b01}); end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    repeat (38) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (st !== 14'h0) begin errors++; $display("FAIL break_hold got %h exp %h", st, 14'h0); end
    send_byte(8'h11, 1'b1);
    checks++;
    if (st !== {1'b1, 3'd1, 8'h11, 2'b00}) begin errors++; $display("FAIL after_break got %h exp %h", st, {1'b1, 3'd1, 8'h11, 2'b00}); end
    pop();
  endtask
  task automatic test_back_to_back();
    send_bits(8'h66);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (st !== {1'b1, 3'd1, 8'h66, 2'b00}) begin errors++; $display("FAIL empty_push_pop got %h exp %h", st, {1'b1, 3'd1, 8'h66, 2'b00}); end
    repeat (4) @(negedge clk);
    pop();
    for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i), 1'b1);
    checks++;
    if (st !== {1'b1, 3'd4, 8'h41, 2'b00}) begin errors++; $display("FAIL full_fill got %h exp %h", st, {1'b1, 3'd4, 8'h41, 2'b00}); end
    send_bits(8'h45);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (st !== {1'b1, 3'd4, 8'h42, 2'b00}) begin errors++; $display("FAIL full_push_pop got %h exp %h", st, {1'b1, 3'd4, 8'h42, 2'b00}); end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_byte !== 8'h42 + 8'(i)) begin errors++; $display("FAIL full_order got %h exp %h", rx_byte, 8'h42 + 8'(i)); end
      pop();
    end
    for (int i = 0; i < 4; i++) send_byte(8'h51 + 8'(i), 1'b1);
    send_bits(8'h55);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checks++;
    if (st !== {1'b1, 3'd4, 8'h51, 2'b10}) begin errors++; $display("FAIL clear_vs_overrun got %h exp %h", st, {1'b1, 3'd4, 8'h51, 2'b10}); end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (8) @(negedge clk);
    end
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    checks++;
    if (st !== 14'h0) begin errors++; $display("FAIL reset_mid got %h exp %h", st, 14'h0); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h7E, 1'b1);
    checks++;
    if (st !== {1'b1, 3'd1, 8'h7E, 2'b00}) begin errors++; $display("FAIL after_reset got %h exp %h", st, {1'b1, 3'd1, 8'h7E, 2'b00}); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
